// File: rtl/armored_tx_reset_seq.sv
// TX PLL / lane-array reset sequencer: power-down, lock wait, analog then digital
// reset release, with lock timeout retry, loss-of-lock recovery and status counters.
module armored_tx_reset_seq #(
    parameter int NUM_PLLS     = 1,
    parameter int CNTR_BITS    = 16,
    parameter int TIMEOUT_BITS = CNTR_BITS + 2
) (
    input  logic                clk100,
    input  logic                rst100,
    input  logic [NUM_PLLS-1:0] pll_locked,
    input  logic                restart,
    output logic                pll_powerdown,
    output logic                rst_txa,
    output logic                rst_txd,
    output logic                tx_ready,
    output logic [2:0]          state,
    output logic [7:0]          timeout_count,
    output logic [7:0]          lol_count
);

    typedef enum logic [2:0] {
        ST_PWRDN     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_ANA_RST   = 3'd2,
        ST_DIG_RST   = 3'd3,
        ST_RUN       = 3'd4
    } state_e;

    localparam logic [CNTR_BITS-1:0]    DWELL_ONE = 1;
    localparam logic [TIMEOUT_BITS-1:0] TMO_ONE   = 1;

    state_e                  state_q, state_d;
    logic [NUM_PLLS-1:0]     sync1_q, sync2_q;
    logic [CNTR_BITS-1:0]    dwell_q, dwell_d;
    logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
    logic [7:0]              tcnt_q, tcnt_d;
    logic [7:0]              lcnt_q, lcnt_d;
    logic                    pd_q, pd_d;
    logic                    txa_q, txa_d;
    logic                    txd_q, txd_d;
    logic                    rdy_q, rdy_d;
    logic                    lock_ok;
    logic                    dwell_done;
    logic                    tmo_done;
    logic                    entry;

    assign lock_ok    = &sync2_q;
    assign dwell_done = (dwell_q == {CNTR_BITS{1'b1}});
    assign tmo_done   = (tmo_q == {TIMEOUT_BITS{1'b1}});

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        lcnt_d  = lcnt_q;
        if (restart) begin
            state_d = ST_PWRDN;
        end else begin
            case (state_q)
                ST_PWRDN: begin
                    if (dwell_done) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock_ok && dwell_done) begin
                        state_d = ST_ANA_RST;
                    end else if (tmo_done) begin
                        state_d = ST_PWRDN;
                        tcnt_d  = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
                    end
                end
                ST_ANA_RST, ST_DIG_RST, ST_RUN: begin
                    if (!lock_ok) begin
                        state_d = ST_WAIT_LOCK;
                        lcnt_d  = (lcnt_q == 8'hFF) ? lcnt_q : lcnt_q + 8'd1;
                    end else if (dwell_done && state_q == ST_ANA_RST) begin
                        state_d = ST_DIG_RST;
                    end else if (dwell_done && state_q == ST_DIG_RST) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_PWRDN;
            endcase
        end
    end

    // A restart re-enters PWRDN even from PWRDN, so it counts as a fresh entry.
    always_comb begin
        entry   = restart || (state_d != state_q);
        dwell_d = dwell_q + DWELL_ONE;
        tmo_d   = tmo_q + TMO_ONE;
        if (entry) begin
            dwell_d = '0;
            tmo_d   = '0;
        end else if (state_q == ST_WAIT_LOCK && !lock_ok) begin
            dwell_d = '0;
        end
    end

    always_comb begin
        pd_d  = (state_d == ST_PWRDN);
        txa_d = (state_d == ST_PWRDN) || (state_d == ST_WAIT_LOCK) || (state_d == ST_ANA_RST);
        txd_d = (state_d != ST_RUN);
        rdy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk100 or posedge rst100) begin
        if (rst100) begin
            state_q <= ST_PWRDN;
            sync1_q <= '0;
            sync2_q <= '0;
            dwell_q <= '0;
            tmo_q   <= '0;
            tcnt_q  <= '0;
            lcnt_q  <= '0;
            pd_q    <= 1'b1;
            txa_q   <= 1'b1;
            txd_q   <= 1'b1;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
            dwell_q <= dwell_d;
            tmo_q   <= tmo_d;
            tcnt_q  <= tcnt_d;
            lcnt_q  <= lcnt_d;
            pd_q    <= pd_d;
            txa_q   <= txa_d;
            txd_q   <= txd_d;
            rdy_q   <= rdy_d;
        end
    end

    assign pll_powerdown = pd_q;
    assign rst_txa       = txa_q;
    assign rst_txd       = txd_q;
    assign tx_ready      = rdy_q;
    assign state         = state_q;
    assign timeout_count = tcnt_q;
    assign lol_count     = lcnt_q;

endmodule

// File: tb/tb_armored_tx_reset_seq.sv
// Bench for armored_tx_reset_seq: expected state transitions (cycle, state, outputs,
// counters) are queued by the driver and checked by a monitor on every state change.
module tb_armored_tx_reset_seq;

    logic       clk100 = 1'b0;
    logic       rst100 = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] pll_locked = 2'b11;
    logic       pll_powerdown, rst_txa, rst_txd, tx_ready;
    logic [2:0] state;
    logic [7:0] timeout_count, lol_count;

    logic [15:0] cyc;
    logic [38:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    armored_tx_reset_seq #(
        .NUM_PLLS     (2),
        .CNTR_BITS    (4),
        .TIMEOUT_BITS (6)
    ) dut (
        .clk100        (clk100),
        .rst100        (rst100),
        .pll_locked    (pll_locked),
        .restart       (restart),
        .pll_powerdown (pll_powerdown),
        .rst_txa       (rst_txa),
        .rst_txd       (rst_txd),
        .tx_ready      (tx_ready),
        .state         (state),
        .timeout_count (timeout_count),
        .lol_count     (lol_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk100 = ~clk100;

    // Edge count since the last reset release: after edge k, cyc == k.
    always @(posedge clk100 or posedge rst100) begin
        if (rst100) cyc <= 16'd0;
        else        cyc <= cyc + 16'd1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog pending=%0d", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    function automatic logic [38:0] mk(input int c, input logic [2:0] st, input int tc, input int lc);
        logic [15:0] c16;
        logic [7:0]  tc8, lc8;
        c16 = c[15:0];
        tc8 = tc[7:0];
        lc8 = lc[7:0];
        mk = {c16, st, st == 3'd0, st <= 3'd2, st != 3'd4, st == 3'd4, tc8, lc8};
    endfunction

    task automatic push(input int c, input logic [2:0] st, input int tc, input int lc);
        exp_q.push_back(mk(c, st, tc, lc));
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk100);
    endtask

    // Asserts rst100 between clock edges and releases it on a falling edge.
    task automatic do_reset();
        @(negedge clk100);
        #2;
        rst100 = 1'b1;
        repeat (3) @(negedge clk100);
        rst100 = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk100);
            n++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d cyc=%0d state=%0d", exp_q.size(), cyc, state);
            exp_q.delete();
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [2:0]  last;
        logic [38:0] act, exp;
        last = 3'd7;
        forever begin
            @(negedge clk100 or posedge rst100);
            #1;
            if (state !== last) begin
                act = {cyc, state, pll_powerdown, rst_txa, rst_txd, tx_ready, timeout_count, lol_count};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_transition cyc=%0d state=%0d act=%h", cyc, state, act);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        failures++;
                        $display("FAIL transition act: cyc=%0d st=%0d pd/txa/txd/rdy=%b tc=%0d lc=%0d required: cyc=%0d st=%0d pd/txa/txd/rdy=%b tc=%0d lc=%0d",
                                 act[38:23], act[22:20], act[19:16], act[15:8], act[7:0],
                                 exp[38:23], exp[22:20], exp[19:16], exp[15:8], exp[7:0]);
                    end
                end
                last = state;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Nominal bring-up, then a one-cycle loss of lock in RUN.
        pll_locked = 2'b11;
        push(0, 3'd0, 0, 0);
        #1 rst100 = 1'b1;
        repeat (3) @(negedge clk100);
        rst100 = 1'b0;
        push(16, 3'd1, 0, 0);
        push(32, 3'd2, 0, 0);
        push(48, 3'd3, 0, 0);
        push(64, 3'd4, 0, 0);
        push(73, 3'd1, 0, 1);
        push(89, 3'd2, 0, 1);
        push(105, 3'd3, 0, 1);
        push(121, 3'd4, 0, 1);
        wait_cyc(70);
        pll_locked = 2'b01;
        wait_cyc(1);
        pll_locked = 2'b11;
        drain(120);

        // Restart in DIG_RST on the same edge as a lock drop, then rst100 mid-DIG_RST.
        push(0, 3'd0, 0, 0);
        do_reset();
        push(16, 3'd1, 0, 0);
        push(32, 3'd2, 0, 0);
        push(48, 3'd3, 0, 0);
        push(53, 3'd0, 0, 0);
        push(69, 3'd1, 0, 0);
        push(85, 3'd2, 0, 0);
        push(101, 3'd3, 0, 0);
        wait_cyc(50);
        pll_locked = 2'b01;
        wait_cyc(1);
        pll_locked = 2'b11;
        wait_cyc(1);
        restart = 1'b1;
        wait_cyc(1);
        restart = 1'b0;
        wait_cyc(52);
        push(0, 3'd0, 0, 0);
        do_reset();
        push(16, 3'd1, 0, 0);
        push(32, 3'd2, 0, 0);
        push(48, 3'd3, 0, 0);
        push(64, 3'd4, 0, 0);
        drain(120);

        // Late lock with a one-cycle dropout while waiting for lock.
        push(0, 3'd0, 0, 0);
        pll_locked = 2'b01;
        do_reset();
        push(16, 3'd1, 0, 0);
        push(69, 3'd2, 0, 0);
        push(85, 3'd3, 0, 0);
        push(101, 3'd4, 0, 0);
        wait_cyc(40);
        pll_locked = 2'b11;
        wait_cyc(10);
        pll_locked = 2'b01;
        wait_cyc(1);
        pll_locked = 2'b11;
        drain(150);

        // Lock never asserts (one brief glitch in the first wait): timeout loop and saturation.
        push(0, 3'd0, 0, 0);
        pll_locked = 2'b01;
        do_reset();
        push(16, 3'd1, 0, 0);
        for (int n = 1; n <= 257; n++) begin
            push(80 * n, 3'd0, (n > 255) ? 255 : n, 0);
            push(80 * n + 16, 3'd1, (n > 255) ? 255 : n, 0);
        end
        wait_cyc(40);
        pll_locked = 2'b11;
        wait_cyc(1);
        pll_locked = 2'b01;
        drain(21000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
